barrier_mask_writer: RTL and testbench
======================================

// Module: barrier_mask_writer
// PURPOSE
//  Multi-shape successor to the single-circle barrier test. Holds NUM_SHAPES programmable circles
//  (centre, radius, enable) and, on start, raster-scans the HPIXELS x VPIXELS fluid grid.
//  Through a 3-stage squared-distance pipeline it writes one barrier bit per cell into the mask RAM.
//  The solver reads that mask RAM. Shape changes use shadow registers and apply only between scans.
// PARAMETERS
//  HPIXELS     320  grid width in cells; HOR_SIZE = $clog2(HPIXELS)
//  VPIXELS     180  grid height in cells; VERT_SIZE = $clog2(VPIXELS)
//  NUM_SHAPES  4    number of circle slots; IDX_W = max(1,$clog2(NUM_SHAPES))
//  RAD_W       8    radius width; ADDR_W = $clog2(HPIXELS*VPIXELS)
// PORTS
//  clk_in         in   1          system clock
//  rst_n_in       in   1          asynchronous, active-low reset
//  start_in       in   1          1-cycle pulse: begin a scan (only accepted in IDLE)
//  busy_out       out  1          high from the accepted start until the done cycle, inclusive
//  done_out       out  1          1-cycle pulse with the final mask write
//  cfg_we_in      in   1          write shadow slot cfg_idx_in
//  cfg_idx_in     in   IDX_W      shadow slot index; writes with index >= NUM_SHAPES are ignored
//  cfg_en_in      in   1          slot enable
//  cfg_hor_in     in   HOR_SIZE   centre column
//  cfg_vert_in    in   VERT_SIZE  centre row
//  cfg_rad_in     in   RAD_W      radius in cells
//  cfg_commit_in  in   1          pulse: copy all shadow slots to active slots
//  mask_we_out    out  1          mask RAM write enable
//  mask_addr_out  out  ADDR_W     vert*HPIXELS + hor
//  mask_data_out  out  1          1 = cell is barrier
// BEHAVIOUR
//  Reset (async assert, sync release):
//   - FSM=IDLE; all outputs 0; scan counters 0; commit_pending=0.
//   - All shadow and active slots cleared (enable=0).
//  FSM IDLE -> SCAN -> DRAIN -> IDLE:
//   - IDLE: start_in -> SCAN with hor=vert=0. busy_out rises the cycle after start.
//   - SCAN: issues one cell per cycle into pipe stage 0. hor increments and wraps at HPIXELS-1,
//     then vert increments. After issuing (HPIXELS-1, VPIXELS-1) -> DRAIN.
//   - DRAIN: waits until the pipeline is empty. done_out is asserted with the last write -> IDLE.
//   - start_in outside IDLE is ignored; it is not queued.
//  Pipeline, fixed latency 3 cycles from issue to mask_we_out:
//   - S1: per slot, dx=|hor-cx| (HOR_SIZE+1 bits) and dy=|vert-cy| (VERT_SIZE+1 bits); address computed.
//   - S2: d2 = dx*dx + dy*dy at full width, no truncation. r2 = rad*rad (2*RAD_W bits).
//   - S3: hit_k = en_k & (d2_k <= r2_k); mask_data_out = OR of hit_k; mask_we_out=1.
//   - The boundary is inclusive: <= r^2, not < r.
//   - A slot with radius 0 marks only its centre cell. An enabled slot wholly off-grid writes nothing.
//   - No enabled slots -> all cells written 0.
//  Config:
//   - cfg_we_in writes the shadow slot in any state.
//   - cfg_commit_in in IDLE: active <= shadow on the next edge.
//   - cfg_commit_in in SCAN/DRAIN: sets commit_pending. The copy happens in the cycle after done_out.
//     Shadow writes made after the commit but before that copy are included in it.
//   - Active slots never change mid-scan, so a scan is always self-consistent.
//   - start_in in the same cycle as an IDLE commit: the scan uses the new config.
//   - cfg_we_in in the same cycle as an IDLE commit: the commit copies the pre-write shadow value.
//  Reset mid-scan: writes stop immediately, no done_out, and the partial mask is left as-is.
// TESTING
//  (Bench: HPIXELS=16, VPIXELS=8, NUM_SHAPES=4, RAD_W=8.)
//  Slot0 = (8,4) r=2, committed, then start:
//   - mask at (8,4),(10,4),(9,5) = 1; (11,4),(10,5) = 0.
//   - Exactly 13 ones.
//  Count check:
//   - 128 writes on consecutive cycles, addresses 0..127 in order.
//   - First write 3 cycles after the scan begins. done_out coincides with addr 127.
//   - busy_out falls the following cycle.
//  No slots enabled -> 128 writes, all data 0. Slot0 r=0 at (0,0) -> only addr 0 is 1.
//  Commit mid-scan (change r to 1 at cycle 50):
//   - The current scan still uses r=2.
//   - The next scan uses r=1 -> 5 ones.
//  Overlap: slot0 (2,2) r=1 and slot1 (3,2) r=1 -> union, 8 ones. start pulsed while busy -> ignored.
//  rst_n_in low at scan cycle 40 -> outputs 0 asynchronously, FSM IDLE, no done_out. A new start
//  then scans all 128 cells with the config held before reset cleared to disabled.

Source files
------------

// File: rtl/barrier_mask_writer_if.sv
// Control, shape-config and mask-RAM write signals of the barrier mask writer.
// Latency: none (signal bundle only).
// Backpressure: none; the mask write side has no ready, so the RAM must take a write every cycle.
interface barrier_mask_writer_if #(
    parameter int HPIXELS    = 320,
    parameter int VPIXELS    = 180,
    parameter int NUM_SHAPES = 4,
    parameter int RAD_W      = 8
);
    localparam int HOR_SIZE  = $clog2(HPIXELS);
    localparam int VERT_SIZE = $clog2(VPIXELS);
    localparam int IDX_W     = (NUM_SHAPES > 1) ? $clog2(NUM_SHAPES) : 1;
    localparam int ADDR_W    = $clog2(HPIXELS * VPIXELS);

    logic                 start_in;
    logic                 busy_out;
    logic                 done_out;
    logic                 cfg_we_in;
    logic [IDX_W-1:0]     cfg_idx_in;
    logic                 cfg_en_in;
    logic [HOR_SIZE-1:0]  cfg_hor_in;
    logic [VERT_SIZE-1:0] cfg_vert_in;
    logic [RAD_W-1:0]     cfg_rad_in;
    logic                 cfg_commit_in;
    logic                 mask_we_out;
    logic [ADDR_W-1:0]    mask_addr_out;
    logic                 mask_data_out;

    // Requester side: drives start and shape config, observes status and mask writes.
    modport master (
        output start_in, cfg_we_in, cfg_idx_in, cfg_en_in, cfg_hor_in, cfg_vert_in,
               cfg_rad_in, cfg_commit_in,
        input  busy_out, done_out, mask_we_out, mask_addr_out, mask_data_out
    );

    // Writer side.
    modport slave (
        input  start_in, cfg_we_in, cfg_idx_in, cfg_en_in, cfg_hor_in, cfg_vert_in,
               cfg_rad_in, cfg_commit_in,
        output busy_out, done_out, mask_we_out, mask_addr_out, mask_data_out
    );
endinterface

// File: rtl/barrier_mask_writer.sv
// Raster-scans the grid against NUM_SHAPES programmable circles and writes one barrier bit per cell.
// Latency: 3 cycles from cell issue to mask write, one cell per cycle; done_out rides the last write.
// Backpressure: none; the mask RAM must accept a write on every cycle of a scan.
module barrier_mask_writer #(
    parameter int HPIXELS    = 320,
    parameter int VPIXELS    = 180,
    parameter int NUM_SHAPES = 4,
    parameter int RAD_W      = 8
) (
    input  logic                 clk_in,
    input  logic                 rst_n_in,
    barrier_mask_writer_if.slave bus
);
    localparam int HOR_SIZE  = $clog2(HPIXELS);
    localparam int VERT_SIZE = $clog2(VPIXELS);
    localparam int ADDR_W    = $clog2(HPIXELS * VPIXELS);
    localparam int DX_W      = HOR_SIZE + 1;
    localparam int DY_W      = VERT_SIZE + 1;
    // Widest possible dx^2 + dy^2, then widened to also hold rad^2 so the compare is exact.
    localparam int D2_W      = ((DX_W > DY_W) ? 2 * DX_W : 2 * DY_W) + 1;
    localparam int CMP_W     = (D2_W > 2 * RAD_W) ? D2_W : 2 * RAD_W;

    localparam logic [HOR_SIZE-1:0]  HOR_LAST  = HOR_SIZE'(HPIXELS - 1);
    localparam logic [VERT_SIZE-1:0] VERT_LAST = VERT_SIZE'(VPIXELS - 1);

    typedef enum logic [1:0] {IDLE, SCAN, DRAIN} state_t;

    typedef struct packed {
        logic                 en;
        logic [HOR_SIZE-1:0]  hor;
        logic [VERT_SIZE-1:0] vert;
        logic [RAD_W-1:0]     rad;
    } slot_t;

    state_t               state;
    logic [HOR_SIZE-1:0]  hor;
    logic [VERT_SIZE-1:0] vert;
    logic [ADDR_W-1:0]    addr_cnt;
    logic                 busy_q;
    logic                 commit_pending;
    slot_t                shadow [NUM_SHAPES];
    slot_t                active [NUM_SHAPES];

    logic                 issue_vld;
    logic                 issue_last;
    logic                 cfg_idx_ok;
    slot_t                cfg_slot;

    // Stage 1: per-slot absolute distances, address carried alongside.
    logic                 v1, l1;
    logic [ADDR_W-1:0]    a1;
    logic [DX_W-1:0]      dx_q [NUM_SHAPES];
    logic [DY_W-1:0]      dy_q [NUM_SHAPES];
    // Stage 2: squared distance and squared radius.
    logic                 v2, l2;
    logic [ADDR_W-1:0]    a2;
    logic [CMP_W-1:0]     d2_q [NUM_SHAPES];
    logic [CMP_W-1:0]     r2_q [NUM_SHAPES];
    // Stage 3: registered mask write.
    logic                 we_q, done_q, data_q;
    logic [ADDR_W-1:0]    addr_q;
    logic                 hit_any;

    assign issue_vld  = (state == SCAN);
    assign issue_last = issue_vld && (hor == HOR_LAST) && (vert == VERT_LAST);
    assign cfg_idx_ok = int'(bus.cfg_idx_in) < NUM_SHAPES;
    assign cfg_slot   = '{en: bus.cfg_en_in, hor: bus.cfg_hor_in, vert: bus.cfg_vert_in,
                          rad: bus.cfg_rad_in};

    assign bus.busy_out      = busy_q;
    assign bus.done_out      = done_q;
    assign bus.mask_we_out   = we_q;
    assign bus.mask_addr_out = addr_q;
    assign bus.mask_data_out = data_q;

    // Scan FSM, raster counters and shadow/active shape slots.
    // Active slots only change while the pipeline is empty, so every scan sees one config.
    // A commit in the same cycle as a shadow write copies the pre-write shadow (NBA ordering).
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state          <= IDLE;
            hor            <= '0;
            vert           <= '0;
            addr_cnt       <= '0;
            busy_q         <= 1'b0;
            commit_pending <= 1'b0;
            for (int k = 0; k < NUM_SHAPES; k++) begin
                shadow[k] <= '0;
                active[k] <= '0;
            end
        end else begin
            if (bus.cfg_we_in && cfg_idx_ok) begin
                shadow[bus.cfg_idx_in] <= cfg_slot;
            end
            case (state)
                IDLE: begin
                    if (bus.cfg_commit_in) begin
                        active <= shadow;
                    end
                    if (bus.start_in) begin
                        state    <= SCAN;
                        busy_q   <= 1'b1;
                        hor      <= '0;
                        vert     <= '0;
                        addr_cnt <= '0;
                    end
                end
                SCAN: begin
                    if (bus.cfg_commit_in) begin
                        commit_pending <= 1'b1;
                    end
                    addr_cnt <= addr_cnt + 1'b1;
                    if (hor == HOR_LAST) begin
                        hor <= '0;
                        if (vert == VERT_LAST) begin
                            vert  <= '0;
                            state <= DRAIN;
                        end else begin
                            vert <= vert + 1'b1;
                        end
                    end else begin
                        hor <= hor + 1'b1;
                    end
                end
                DRAIN: begin
                    // done_q marks the final write; leave on the following edge and apply
                    // any deferred commit, including a commit arriving in the done cycle itself.
                    if (done_q) begin
                        state          <= IDLE;
                        busy_q         <= 1'b0;
                        commit_pending <= 1'b0;
                        if (commit_pending || bus.cfg_commit_in) begin
                            active <= shadow;
                        end
                    end else if (bus.cfg_commit_in) begin
                        commit_pending <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Stage 3 combine: a cell is barrier if any enabled circle contains it (boundary inclusive).
    always_comb begin
        hit_any = 1'b0;
        for (int k = 0; k < NUM_SHAPES; k++) begin
            if (active[k].en && (d2_q[k] <= r2_q[k])) begin
                hit_any = 1'b1;
            end
        end
    end

    // Three-stage squared-distance pipeline feeding the mask RAM write port.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            v1     <= 1'b0;
            l1     <= 1'b0;
            a1     <= '0;
            v2     <= 1'b0;
            l2     <= 1'b0;
            a2     <= '0;
            we_q   <= 1'b0;
            done_q <= 1'b0;
            addr_q <= '0;
            data_q <= 1'b0;
            for (int k = 0; k < NUM_SHAPES; k++) begin
                dx_q[k] <= '0;
                dy_q[k] <= '0;
                d2_q[k] <= '0;
                r2_q[k] <= '0;
            end
        end else begin
            v1 <= issue_vld;
            l1 <= issue_last;
            a1 <= addr_cnt;
            v2 <= v1;
            l2 <= l1;
            a2 <= a1;
            for (int k = 0; k < NUM_SHAPES; k++) begin
                dx_q[k] <= (hor >= active[k].hor) ? DX_W'(hor - active[k].hor)
                                                  : DX_W'(active[k].hor - hor);
                dy_q[k] <= (vert >= active[k].vert) ? DY_W'(vert - active[k].vert)
                                                    : DY_W'(active[k].vert - vert);
                d2_q[k] <= CMP_W'(dx_q[k]) * CMP_W'(dx_q[k]) + CMP_W'(dy_q[k]) * CMP_W'(dy_q[k]);
                r2_q[k] <= CMP_W'(active[k].rad) * CMP_W'(active[k].rad);
            end
            we_q   <= v2;
            done_q <= l2;
            addr_q <= v2 ? a2 : '0;
            data_q <= v2 && hit_any;
        end
    end
endmodule

// File: tb/tb_barrier_mask_writer.sv
// Self-checking bench for barrier_mask_writer on a 16x8 grid with 4 circle slots.
// Latency: checks the 3-cycle issue-to-write latency and done/busy timing.
// Backpressure: none on the DUT; every write is matched against a scoreboard queue.
module tb_barrier_mask_writer;
    localparam int HP = 16, VP = 8, NS = 4, RW = 8, IW = 2, NCELL = HP * VP;

    typedef struct packed {
        bit       en;
        bit [3:0] cx;
        bit [2:0] cy;
        bit [7:0] r;
    } tslot_t;
    typedef tslot_t [NS-1:0] cfg_t;
    typedef struct packed {
        bit [6:0] addr;
        bit       data;
    } exp_t;
    typedef struct {
        cfg_t cfg;
        int   ones;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    barrier_mask_writer_if #(.HPIXELS(HP), .VPIXELS(VP), .NUM_SHAPES(NS), .RAD_W(RW)) bus ();
    barrier_mask_writer #(.HPIXELS(HP), .VPIXELS(VP), .NUM_SHAPES(NS), .RAD_W(RW)) dut (
        .clk_in(clk), .rst_n_in(rst_n), .bus(bus)
    );

    int   n_tests = 0, n_fail = 0;
    int   cyc = 0;
    exp_t sb_q[$];
    cfg_t shadow_m = '0, active_m = '0;
    int   wr_cnt = 0, ones_cnt = 0, first_wr_cyc = 0, last_wr_cyc = 0, done_cyc = 0, start_cyc = 0;
    bit   done_seen = 0, done_prev = 0;
    bit   mask_img [NCELL];

    task automatic check(string name, int act, int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic tslot_t mk(bit en, int cx, int cy, int r);
        tslot_t s;
        s.en = en; s.cx = 4'(cx); s.cy = 3'(cy); s.r = 8'(r);
        return s;
    endfunction

    // Geometric reference: inside any enabled circle, boundary inclusive.
    function automatic bit model_bit(cfg_t c, int x, int y);
        for (int k = 0; k < NS; k++) begin
            int dx, dy, rr;
            dx = x - int'(c[k].cx);
            dy = y - int'(c[k].cy);
            rr = int'(c[k].r);
            if (c[k].en && (dx * dx + dy * dy <= rr * rr)) return 1'b1;
        end
        return 1'b0;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Output monitor: sampled on the falling edge, scoreboard pop per write.
    always @(negedge clk) begin
        exp_t e;
        if (done_prev) check("busy_fall_after_done", bus.busy_out, 0);
        done_prev = bus.done_out;
        if (bus.mask_we_out) begin
            check("sb_nonempty_on_write", int'(sb_q.size() != 0), 1);
            if (sb_q.size() != 0) begin
                e = sb_q.pop_front();
                check("wr_addr", bus.mask_addr_out, e.addr);
                check("wr_data", bus.mask_data_out, e.data);
            end
            if (wr_cnt == 0) first_wr_cyc = cyc;
            else check("wr_consecutive", cyc - last_wr_cyc, 1);
            last_wr_cyc = cyc;
            wr_cnt++;
            ones_cnt += int'(bus.mask_data_out);
            mask_img[bus.mask_addr_out] = bus.mask_data_out;
        end
        if (bus.done_out) begin
            check("done_with_we", bus.mask_we_out, 1);
            check("done_addr", bus.mask_addr_out, NCELL - 1);
            check("busy_at_done", bus.busy_out, 1);
            done_cyc  = cyc;
            done_seen = 1'b1;
        end
    end

    task automatic drive_cfg(int idx, tslot_t s);
        bus.cfg_idx_in  = IW'(idx);
        bus.cfg_en_in   = s.en;
        bus.cfg_hor_in  = s.cx;
        bus.cfg_vert_in = s.cy;
        bus.cfg_rad_in  = s.r;
    endtask

    task automatic cfg_write(int idx, tslot_t s);
        drive_cfg(idx, s);
        bus.cfg_we_in = 1'b1;
        @(posedge clk); #1;
        bus.cfg_we_in = 1'b0;
        shadow_m[idx] = s;
    endtask

    task automatic commit_idle();
        bus.cfg_commit_in = 1'b1;
        @(posedge clk); #1;
        bus.cfg_commit_in = 1'b0;
        active_m = shadow_m;
    endtask

    // Clear per-scan counters and queue the expected 128 writes from the active model.
    task automatic arm_scan();
        wr_cnt = 0; ones_cnt = 0; done_seen = 1'b0;
        start_cyc = cyc;
        for (int y = 0; y < VP; y++)
            for (int x = 0; x < HP; x++)
                sb_q.push_back('{addr: 7'(y * HP + x), data: model_bit(active_m, x, y)});
    endtask

    task automatic start_scan();
        check("busy_before_start", bus.busy_out, 0);
        arm_scan();
        bus.start_in = 1'b1;
        @(posedge clk); #1;
        bus.start_in = 1'b0;
        check("busy_after_start", bus.busy_out, 1);
    endtask

    task automatic wait_done();
        int n = 0;
        while (!done_seen && n < 400) begin
            @(posedge clk); #1;
            n++;
        end
        check("done_timeout", int'(done_seen), 1);
        @(posedge clk); #1;
    endtask

    task automatic scan_checks(string name, int exp_ones);
        check({name, "_writes"}, wr_cnt, NCELL);
        check({name, "_ones"}, ones_cnt, exp_ones);
        check({name, "_first_latency"}, first_wr_cyc - (start_cyc + 1), 3);
        check({name, "_done_vs_first"}, done_cyc - first_wr_cyc, NCELL - 1);
        check({name, "_sb_empty"}, sb_q.size(), 0);
        check({name, "_busy_low"}, bus.busy_out, 0);
    endtask

    vec_t vecs[6];

    initial begin
        bus.start_in = 1'b0; bus.cfg_we_in = 1'b0; bus.cfg_commit_in = 1'b0;
        drive_cfg(0, '0);

        for (int i = 0; i < 6; i++) vecs[i].cfg = '0;
        vecs[0].cfg[0] = mk(1, 8, 4, 2);                                  vecs[0].ones = 13;
        vecs[1].ones = 0;
        vecs[2].cfg[0] = mk(1, 0, 0, 0);                                  vecs[2].ones = 1;
        vecs[3].cfg[0] = mk(1, 2, 2, 1); vecs[3].cfg[1] = mk(1, 3, 2, 1); vecs[3].ones = 8;
        vecs[4].cfg[0] = mk(0, 0, 0, 255); vecs[4].cfg[2] = mk(1, 15, 7, 3); vecs[4].ones = 11;
        vecs[5].cfg[1] = mk(1, 0, 7, 20);                                 vecs[5].ones = 128;

        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        check("rst_we", bus.mask_we_out, 0);
        check("rst_done", bus.done_out, 0);
        check("rst_busy", bus.busy_out, 0);
        check("rst_addr", bus.mask_addr_out, 0);
        check("rst_data", bus.mask_data_out, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Table-driven scans, each with an ignored start pulse mid-scan.
        for (int i = 0; i < 6; i++) begin
            for (int k = 0; k < NS; k++) cfg_write(k, vecs[i].cfg[k]);
            commit_idle();
            start_scan();
            repeat (20) @(posedge clk);
            #1;
            bus.start_in = 1'b1;
            @(posedge clk); #1;
            bus.start_in = 1'b0;
            wait_done();
            scan_checks($sformatf("vec%0d", i), vecs[i].ones);
            if (i == 0) begin
                check("v0_cell_8_4", mask_img[72], 1);
                check("v0_cell_10_4", mask_img[74], 1);
                check("v0_cell_9_5", mask_img[89], 1);
                check("v0_cell_11_4", mask_img[75], 0);
                check("v0_cell_10_5", mask_img[90], 0);
            end
            if (i == 2) check("v2_cell_0", mask_img[0], 1);
            repeat (10) @(posedge clk);
            #1;
            check($sformatf("vec%0d_no_rescan", i), wr_cnt, NCELL);
            check($sformatf("vec%0d_idle_busy", i), bus.busy_out, 0);
        end

        // Commit mid-scan: current scan keeps r=2; later shadow write joins the deferred copy.
        for (int k = 0; k < NS; k++) cfg_write(k, '0);
        cfg_write(0, mk(1, 8, 4, 2));
        commit_idle();
        start_scan();
        repeat (49) @(posedge clk);
        #1;
        cfg_write(0, mk(1, 8, 4, 1));
        bus.cfg_commit_in = 1'b1;
        @(posedge clk); #1;
        bus.cfg_commit_in = 1'b0;
        cfg_write(1, mk(1, 0, 0, 0));
        wait_done();
        scan_checks("midcommit_cur", 13);
        active_m = shadow_m;
        start_scan();
        wait_done();
        scan_checks("midcommit_next", 6);

        // Same-cycle shadow write + IDLE commit + start: pre-write shadow, new config used.
        cfg_write(0, mk(1, 8, 4, 2));
        active_m = shadow_m;
        check("busy_before_combo", bus.busy_out, 0);
        arm_scan();
        drive_cfg(1, mk(0, 0, 0, 0));
        bus.cfg_we_in = 1'b1; bus.cfg_commit_in = 1'b1; bus.start_in = 1'b1;
        @(posedge clk); #1;
        bus.cfg_we_in = 1'b0; bus.cfg_commit_in = 1'b0; bus.start_in = 1'b0;
        shadow_m[1] = mk(0, 0, 0, 0);
        wait_done();
        scan_checks("combo", 14);
        commit_idle();
        start_scan();
        wait_done();
        scan_checks("combo_next", 13);

        // Reset mid-scan: outputs drop at once, no done, config cleared.
        start_scan();
        repeat (39) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("midrst_we", bus.mask_we_out, 0);
        check("midrst_busy", bus.busy_out, 0);
        check("midrst_done", bus.done_out, 0);
        check("midrst_partial", int'(wr_cnt < NCELL), 1);
        repeat (3) @(posedge clk);
        #1;
        check("midrst_no_done", int'(done_seen), 0);
        sb_q.delete();
        shadow_m = '0;
        active_m = '0;
        rst_n = 1'b1;
        @(posedge clk); #1;
        start_scan();
        wait_done();
        scan_checks("post_rst", 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end
endmodule
